// File: rtl/perf_counter_sampler.sv
// perf_counter_sampler
// Walks the performance-counter port from FIRST_IDX to LAST_IDX on a periodic
// tick or software request and queues {index, value, last} for the trace
// streamer. CSR accesses share the counter port and take priority over the walk.
module perf_counter_sampler #(
   parameter logic [4:0] FIRST_IDX  = 5'd3,
   parameter logic [4:0] LAST_IDX   = 5'd18,
   parameter int         FIFO_DEPTH = 4,
   parameter int         INTERVAL_W = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  debug_mode_i,
   input  logic                  enable_i,
   input  logic [INTERVAL_W-1:0] interval_i,
   input  logic                  clear_on_read_i,
   input  logic                  sample_req_i,
   input  logic                  csr_req_i,
   input  logic [4:0]            csr_addr_i,
   input  logic                  csr_we_i,
   input  logic [63:0]           csr_wdata_i,
   output logic [63:0]           csr_rdata_o,
   output logic [4:0]            pc_addr_o,
   output logic                  pc_we_o,
   output logic [63:0]           pc_wdata_o,
   input  logic [63:0]           pc_rdata_i,
   output logic                  sample_valid_o,
   input  logic                  sample_ready_i,
   output logic [4:0]            sample_idx_o,
   output logic [63:0]           sample_data_o,
   output logic                  sample_last_o,
   output logic                  busy_o,
   output logic [15:0]           missed_o
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam int ENTRY_W = 5 + 64 + 1;

   typedef enum logic {ST_IDLE, ST_WALK} state_t;

   state_t               r_state, w_state_next;
   logic [4:0]           r_cur_idx, w_cur_idx_next;
   logic                 r_pending, w_pending_next;
   logic [15:0]          r_missed, w_missed_next;
   logic [INTERVAL_W-1:0] r_timer;

   logic [ENTRY_W-1:0]   r_fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
   logic [CNT_W-1:0]     r_count;

   logic                 w_count_en, w_tick, w_trigger, w_start, w_defer;
   logic                 w_full, w_step, w_push, w_pop;
   logic [ENTRY_W-1:0]   w_push_entry;

   // Timer only runs while periodic sampling is fully enabled.
   assign w_count_en = enable_i && !debug_mode_i && (interval_i != '0);
   // >= rather than == so a shrinking interval cannot strand the timer above it.
   assign w_tick     = w_count_en && (r_timer >= (interval_i - INTERVAL_W'(1)));
   assign w_trigger  = w_tick || sample_req_i;

   // A trigger either starts a walk right away or is deferred into pending.
   assign w_start = (r_state == ST_IDLE) && !debug_mode_i && (w_trigger || r_pending);
   assign w_defer = w_trigger && !w_start;

   // Full is taken from the registered count, so a same-cycle pop does not help.
   assign w_full       = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_step       = (r_state == ST_WALK) && !csr_req_i && !w_full;
   assign w_push       = w_step;
   assign w_pop        = (r_count != '0) && sample_ready_i;
   assign w_push_entry = {r_cur_idx, pc_rdata_i, (r_cur_idx == LAST_IDX)};

   // Sampling-interval timer: cleared when disabled, frozen in debug.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_timer <= '0;
      end else if (!enable_i || (interval_i == '0)) begin
         r_timer <= '0;
      end else if (!debug_mode_i) begin
         r_timer <= w_tick ? '0 : r_timer + INTERVAL_W'(1);
      end
   end

   // Counter port mux: CSR access first, then a walk read (with optional clear).
   always_comb begin
      pc_addr_o   = 5'd0;
      pc_we_o     = 1'b0;
      pc_wdata_o  = 64'd0;
      csr_rdata_o = 64'd0;
      if (csr_req_i) begin
         pc_addr_o   = csr_addr_i;
         pc_we_o     = csr_we_i;
         pc_wdata_o  = csr_wdata_i;
         csr_rdata_o = pc_rdata_i;
      end else if (w_step) begin
         pc_addr_o  = r_cur_idx;
         pc_we_o    = clear_on_read_i;
         pc_wdata_o = 64'd0;
      end
   end

   // Walk FSM state, index, pending flag and drop counter registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= ST_IDLE;
         r_cur_idx <= 5'd0;
         r_pending <= 1'b0;
         r_missed  <= 16'd0;
      end else begin
         r_state   <= w_state_next;
         r_cur_idx <= w_cur_idx_next;
         r_pending <= w_pending_next;
         r_missed  <= w_missed_next;
      end
   end

   // Next-state: start/advance the walk and account for deferred triggers.
   always_comb begin
      w_state_next   = r_state;
      w_cur_idx_next = r_cur_idx;
      w_pending_next = r_pending;
      w_missed_next  = r_missed;
      case (r_state)
         ST_IDLE: begin
            if (w_start) begin
               w_state_next   = ST_WALK;
               w_cur_idx_next = FIRST_IDX;
               w_pending_next = 1'b0;
            end
         end
         ST_WALK: begin
            if (w_step) begin
               w_cur_idx_next = r_cur_idx + 5'd1;
               if (r_cur_idx == LAST_IDX) begin
                  w_state_next = ST_IDLE;
               end
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
      if (w_defer) begin
         if (!r_pending) begin
            w_pending_next = 1'b1;
         end else if (r_missed != 16'hFFFF) begin
            w_missed_next = r_missed + 16'd1;
         end
      end
   end

   // Output FIFO storage and pointers; head is read straight from the entry registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_fifo_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= w_push_entry;
            r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   assign sample_valid_o = (r_count != '0);
   assign {sample_idx_o, sample_data_o, sample_last_o} = r_fifo_mem[r_rd_ptr];
   assign busy_o   = (r_state == ST_WALK);
   assign missed_o = r_missed;

endmodule

// File: tb/tb_perf_counter_sampler.sv
// Testbench for perf_counter_sampler: an SRAM-like counter array answers the
// counter port, and a queue-based reference model predicts every output.
module tb_perf_counter_sampler;

   localparam int DEPTH = 4;
   localparam int FIRST = 3;
   localparam int LAST  = 18;
   localparam int NSNAP = LAST - FIRST + 1;

   typedef struct packed {
      logic [4:0]  idx;
      logic [63:0] data;
      logic        last;
   } ent_t;

   logic        clk, rst;
   logic        dbg, en, clr, req, ready;
   logic [31:0] intv;
   logic        csr_req, csr_we;
   logic [4:0]  csr_addr;
   logic [63:0] csr_wdata, csr_rdata;
   logic [4:0]  pc_addr;
   logic        pc_we;
   logic [63:0] pc_wdata, pc_rdata;
   logic        valid, busy, s_last;
   logic [4:0]  s_idx;
   logic [63:0] s_data;
   logic [15:0] missed;
   logic        do_preload;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   bit          m_walk, m_pending;
   logic [4:0]  m_idx;
   int          m_missed;
   logic [31:0] m_timer;
   ent_t        m_q[$];
   logic [63:0] m_ctr [32];
   ent_t        got_q[$];

   // last observed values
   logic        obs_busy, obs_valid;
   logic [15:0] obs_missed;
   logic [63:0] obs_csr_rdata;
   logic [4:0]  obs_pc_addr;

   logic [63:0] ctr [32];

   perf_counter_sampler #(
      .FIRST_IDX(5'd3), .LAST_IDX(5'd18), .FIFO_DEPTH(DEPTH), .INTERVAL_W(32)
   ) dut (
      .clk_i(clk), .rst_i(rst), .debug_mode_i(dbg), .enable_i(en),
      .interval_i(intv), .clear_on_read_i(clr), .sample_req_i(req),
      .csr_req_i(csr_req), .csr_addr_i(csr_addr), .csr_we_i(csr_we),
      .csr_wdata_i(csr_wdata), .csr_rdata_o(csr_rdata),
      .pc_addr_o(pc_addr), .pc_we_o(pc_we), .pc_wdata_o(pc_wdata),
      .pc_rdata_i(pc_rdata), .sample_valid_o(valid), .sample_ready_i(ready),
      .sample_idx_o(s_idx), .sample_data_o(s_data), .sample_last_o(s_last),
      .busy_o(busy), .missed_o(missed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counter array: combinational read, write lands at the next clock edge.
   assign pc_rdata = ctr[pc_addr];
   always @(posedge clk) begin
      if (do_preload) begin
         for (int i = 0; i < 32; i++) ctr[i] <= 64'(i * 10);
      end else if (pc_we) begin
         ctr[pc_addr] <= pc_wdata;
      end
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock of comparison plus reference-model advance.
   task automatic step();
      ent_t        e;
      bit          tick, full, stp, trig, start, was_walk;
      logic [4:0]  exp_addr;
      logic        exp_we;
      logic [63:0] exp_wd, exp_rd;
      @(negedge clk);
      if (rst) begin
         m_walk = 0; m_pending = 0; m_idx = '0; m_missed = 0; m_timer = '0;
         m_q.delete();
      end
      tick = en && !dbg && (intv != 0) && (m_timer >= intv - 32'd1);
      full = (m_q.size() == DEPTH);
      stp  = m_walk && !csr_req && !full;
      exp_addr = 5'd0; exp_we = 1'b0; exp_wd = 64'd0; exp_rd = 64'd0;
      if (csr_req) begin
         exp_addr = csr_addr; exp_we = csr_we; exp_wd = csr_wdata; exp_rd = m_ctr[csr_addr];
      end else if (stp) begin
         exp_addr = m_idx; exp_we = clr;
      end
      check_val("busy", 64'(busy), 64'(m_walk));
      check_val("valid", 64'(valid), 64'(m_q.size() != 0));
      if (m_q.size() != 0) begin
         check_val("head_idx", 64'(s_idx), 64'(m_q[0].idx));
         check_val("head_data", s_data, m_q[0].data);
         check_val("head_last", 64'(s_last), 64'(m_q[0].last));
      end
      check_val("pc_addr", 64'(pc_addr), 64'(exp_addr));
      check_val("pc_we", 64'(pc_we), 64'(exp_we));
      check_val("pc_wdata", pc_wdata, exp_wd);
      check_val("csr_rdata", csr_rdata, exp_rd);
      check_val("missed", 64'(missed), 64'(m_missed));
      obs_busy = busy; obs_valid = valid; obs_missed = missed;
      obs_csr_rdata = csr_rdata; obs_pc_addr = pc_addr;
      if (valid && ready) begin
         e.idx = s_idx; e.data = s_data; e.last = s_last;
         got_q.push_back(e);
         $display("sample idx=%0d data=%0d last=%0d", s_idx, s_data, s_last);
      end
      if (!rst) begin
         if (m_q.size() != 0 && ready) void'(m_q.pop_front());
         if (stp) begin
            e.idx = m_idx; e.data = m_ctr[m_idx]; e.last = (m_idx == LAST);
            m_q.push_back(e);
         end
         if (do_preload) begin
            for (int i = 0; i < 32; i++) m_ctr[i] = 64'(i * 10);
         end else if (csr_req && csr_we) begin
            m_ctr[csr_addr] = csr_wdata;
         end else if (stp && clr) begin
            m_ctr[m_idx] = 64'd0;
         end
         was_walk = m_walk;
         if (stp) begin
            if (m_idx == LAST) m_walk = 0;
            m_idx = m_idx + 5'd1;
         end
         trig  = tick || req;
         start = !was_walk && !dbg && (trig || m_pending);
         if (start) begin
            m_walk = 1; m_idx = 5'(FIRST); m_pending = 0;
         end else if (trig) begin
            if (m_pending) begin
               if (m_missed < 16'hFFFF) m_missed++;
            end else begin
               m_pending = 1;
            end
         end
         if (!en || intv == 0) m_timer = '0;
         else if (!dbg) m_timer = tick ? 32'd0 : m_timer + 32'd1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic pulse_req();
      req = 1'b1; step(); req = 1'b0;
   endtask

   task automatic preload();
      do_preload = 1'b1; step(); do_preload = 1'b0;
   endtask

   // Delivered entries must form whole snapshots of idx*10 (or zero) values.
   task automatic check_snaps(input string tag, input int nsnap, input bit zero);
      check_val({tag, "_count"}, 64'(got_q.size()), 64'(nsnap * NSNAP));
      for (int i = 0; i < got_q.size() && i < nsnap * NSNAP; i++) begin
         int ix;
         ix = FIRST + (i % NSNAP);
         check_val({tag, "_idx"}, 64'(got_q[i].idx), 64'(ix));
         check_val({tag, "_data"}, got_q[i].data, zero ? 64'd0 : 64'(ix * 10));
         check_val({tag, "_last"}, 64'(got_q[i].last), 64'(ix == LAST));
      end
      got_q.delete();
   endtask

   initial begin
      rst = 1; dbg = 0; en = 0; clr = 0; req = 0; ready = 1; intv = 32'd0;
      csr_req = 0; csr_we = 0; csr_addr = '0; csr_wdata = '0; do_preload = 0;
      for (int i = 0; i < 32; i++) m_ctr[i] = 64'd0;
      run(2);
      rst = 0;
      preload();
      run(2);
      got_q.delete();

      // periodic sampling every 100 cycles
      intv = 32'd100; en = 1;
      run(230);
      en = 0;
      run(3);
      check_snaps("periodic", 2, 0);

      // one software walk with clear-on-read, then CSR reads see zeros
      clr = 1;
      pulse_req();
      run(25);
      clr = 0;
      check_snaps("clear_walk", 1, 0);
      for (int ix = FIRST; ix <= LAST; ix++) begin
         csr_req = 1; csr_addr = 5'(ix);
         step();
         check_val("csr_after_clear", obs_csr_rdata, 64'd0);
      end
      csr_req = 0;
      preload();

      // consumer stalls: FIFO fills, walk holds, then drains in order
      clr = 1; ready = 0;
      pulse_req();
      run(30);
      check_val("stall_busy", 64'(obs_busy), 64'd1);
      check_val("stall_valid", 64'(obs_valid), 64'd1);
      check_val("stall_delivered", 64'(got_q.size()), 64'd0);
      ready = 1;
      run(30);
      clr = 0;
      check_snaps("stall", 1, 0);
      preload();

      // CSR traffic parks the walk at idx 7
      pulse_req();
      for (int k = 0; k < 40 && !(m_walk && m_idx == 5'd7); k++) step();
      for (int k = 0; k < 5; k++) begin
         csr_req = 1; csr_addr = 5'($urandom_range(0, 31));
         step();
      end
      csr_req = 0;
      step();
      check_val("resume_idx", 64'(obs_pc_addr), 64'd7);
      run(25);
      check_snaps("csr_hold", 1, 0);

      // reset in the middle of a walk discards the snapshot
      pulse_req();
      run(5);
      rst = 1;
      run(2);
      check_val("rst_busy", 64'(obs_busy), 64'd0);
      check_val("rst_valid", 64'(obs_valid), 64'd0);
      rst = 0;
      run(2);
      got_q.delete();

      // three requests in one walk: one extra walk, one drop
      pulse_req(); run(2);
      pulse_req(); run(2);
      pulse_req();
      run(45);
      check_val("missed_one", 64'(obs_missed), 64'd1);
      check_snaps("triple", 2, 0);

      // debug freezes the timer and holds a request pending
      dbg = 1; intv = 32'd10; en = 1;
      run(20);
      pulse_req();
      run(29);
      check_val("dbg_busy", 64'(obs_busy), 64'd0);
      check_val("dbg_delivered", 64'(got_q.size()), 64'd0);
      dbg = 0; en = 0;
      step();
      check_val("dbg_idle_cycle", 64'(obs_busy), 64'd0);
      step();
      check_val("dbg_walk_start", 64'(obs_busy), 64'd1);
      run(25);
      check_snaps("dbg", 1, 0);

      // randomized traffic against the model
      intv = 32'($urandom_range(20, 60)); en = 1;
      for (int c = 0; c < 2500; c++) begin
         ready    = ($urandom_range(0, 3) != 0);
         req      = ($urandom_range(0, 29) == 0);
         csr_req  = ($urandom_range(0, 5) == 0);
         csr_we   = csr_req && ($urandom_range(0, 3) == 0);
         csr_addr = 5'($urandom_range(0, 31));
         csr_wdata = {32'($urandom), 32'($urandom)};
         if ($urandom_range(0, 99) == 0) dbg = ~dbg;
         if ($urandom_range(0, 199) == 0) clr = ~clr;
         step();
      end
      req = 0; csr_req = 0; csr_we = 0; dbg = 0; en = 0; ready = 1;
      run(40);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
